// File: rtl/repsig_pkg.sv
// Shared constants and token classification for the repeat-signal generator.
package repsig_pkg;

  localparam int TOKEN_W = 17;

  localparam logic [TOKEN_W-1:0] TOK_DONE = 17'h10100;
  localparam logic [TOKEN_W-1:0] TOK_R    = 17'h00001;

  typedef enum logic [1:0] {
    KIND_DATA  = 2'd0,
    KIND_STOP  = 2'd1,
    KIND_DONE  = 2'd2,
    KIND_OTHER = 2'd3
  } tok_kind_e;

  function automatic tok_kind_e classify(input logic [TOKEN_W-1:0] tok);
    tok_kind_e kind;
    kind = KIND_OTHER;
    if (!tok[16]) begin
      kind = KIND_DATA;
    end else begin
      case (tok[9:8])
        2'b00:   kind = KIND_STOP;
        2'b01:   kind = KIND_DONE;
        default: kind = KIND_OTHER;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/repsig_if.sv
// Base coordinate input stream and repeat-signal output stream of the generator.
// Handshake: a token moves on a rising clk edge when valid && ready (and clk_en);
// valid never waits on ready, and data/valid stay stable while valid && !ready.
interface repsig_if;
  import repsig_pkg::*;

  logic [TOKEN_W-1:0] base_data_in;
  logic               base_data_in_valid;
  logic               base_data_in_ready;
  logic [TOKEN_W-1:0] repsig_data_out;
  logic               repsig_data_out_valid;
  logic               repsig_data_out_ready;

  modport slave (
    input  base_data_in, base_data_in_valid, repsig_data_out_ready,
    output base_data_in_ready, repsig_data_out, repsig_data_out_valid
  );

  modport master (
    output base_data_in, base_data_in_valid, repsig_data_out_ready,
    input  base_data_in_ready, repsig_data_out, repsig_data_out_valid
  );
endinterface

// File: rtl/reg_fifo.sv
// Register-based ready/valid FIFO with synchronous flush and clock enable.
// push_ready is registered, so a pop on a full FIFO frees the slot only next cycle.
module reg_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          ready_q;
  logic          push, pop;

  assign push       = clk_en && push_valid && ready_q;
  assign pop        = clk_en && pop_valid && pop_ready;
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign push_ready = ready_q;

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_n = count + 1'b1;
        2'b01:   count_n = count - 1'b1;
        default: count_n = count;
      endcase
    end
  end

  // ready_q is low throughout reset and follows the next occupancy afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count   <= count_n;
      ready_q <= (count_n != FULL_CNT);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/repeat_signal_generator.sv
// Turns a base coordinate stream into a repeat-signal stream (one token out per token in).
// Define REPSIG_OUT_FIFO_EN for a 2-entry output FIFO instead of a single output register.
module repeat_signal_generator
  import repsig_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic [15:0] stop_lvl,
  repsig_if.slave     bus
);
  logic               in_ready, in_valid, stage_ready;
  logic [TOKEN_W-1:0] in_data, xform;
  logic               out_valid;
  logic [TOKEN_W-1:0] out_data;
  logic               unused_stop_hi;

  assign unused_stop_hi = ^stop_lvl[15:8];

  reg_fifo #(.DEPTH(2), .W(TOKEN_W)) u_in_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .flush      (flush),
    .push_valid (tile_en && bus.base_data_in_valid),
    .push_ready (in_ready),
    .push_data  (bus.base_data_in),
    .pop_valid  (in_valid),
    .pop_ready  (tile_en && stage_ready),
    .pop_data   (in_data)
  );

  assign bus.base_data_in_ready = tile_en && in_ready;

  // Stop levels wrap modulo 256; the rest of the stop token passes through.
  always_comb begin
    xform = in_data;
    case (classify(in_data))
      KIND_DATA: xform = TOK_R;
      KIND_STOP: xform = {in_data[16:8], in_data[7:0] + stop_lvl[7:0]};
      KIND_DONE: xform = TOK_DONE;
      default:   xform = in_data;
    endcase
  end

`ifdef REPSIG_OUT_FIFO_EN
  reg_fifo #(.DEPTH(2), .W(TOKEN_W)) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .flush      (flush),
    .push_valid (tile_en && in_valid),
    .push_ready (stage_ready),
    .push_data  (xform),
    .pop_valid  (out_valid),
    .pop_ready  (tile_en && bus.repsig_data_out_ready),
    .pop_data   (out_data)
  );
`else
  logic out_pop, out_load;

  assign out_pop     = clk_en && tile_en && out_valid && bus.repsig_data_out_ready;
  assign stage_ready = !out_valid || out_pop;
  assign out_load    = clk_en && tile_en && in_valid && stage_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= xform;
    end else if (out_pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign bus.repsig_data_out_valid = tile_en && out_valid;
  assign bus.repsig_data_out       = out_data;
endmodule

// File: tb/tb_repeat_signal_generator.sv
// Bench for repeat_signal_generator: table vectors, random streams against a token model,
// enable/flush/reset corner sequences and a throughput measurement.
module tb_repeat_signal_generator;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, tile_en;
  logic [15:0] stop_lvl;

  repsig_if bus ();

  repeat_signal_generator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .flush    (flush),
    .tile_en  (tile_en),
    .stop_lvl (stop_lvl),
    .bus      (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic [16:0] src_q[$];
  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int cyc = 0;
  int out_cnt = 0;
  int first_in = -1;
  int last_out = 0;
  bit tp_arm = 0;
  bit saw_full = 0;
  bit in_fire = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference transform written straight from the token rules.
  function automatic logic [16:0] model_tok(input logic [16:0] tok, input logic [15:0] lvl);
    int new_lvl;
    if (tok[16] == 1'b0) return 17'h00001;
    if (tok[9:8] == 2'b00) begin
      new_lvl = (int'(tok[7:0]) + int'(lvl[7:0])) % 256;
      return {tok[16:8], new_lvl[7:0]};
    end
    if (tok[9:8] == 2'b01) return 17'h10100;
    return tok;
  endfunction

  function automatic logic [16:0] rand_tok();
    int r;
    logic [15:0] pay;
    logic [7:0] lv;
    r   = $urandom_range(99);
    pay = 16'($urandom);
    lv  = 8'($urandom);
    if (r < 50) return {1'b0, pay};
    if (r < 75) return {1'b1, 8'h00, lv};
    if (r < 85) return 17'h10100;
    return {1'b1, 6'h00, 1'b1, pay[0], lv};
  endfunction

  // ---------------- monitor (samples on the falling edge) ----------------
  logic        prev_hold = 0, prev_ce_low = 0, prev_valid = 0, prev_rdy = 0, prev_te = 0;
  logic [16:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    in_fire = 0;
    if (!rst_n) begin
      prev_hold   = 0;
      prev_ce_low = 0;
    end else if (flush) begin
      exp_q.delete();
      prev_hold   = 0;
      prev_ce_low = 0;
    end else begin
      if (!tile_en) begin
        chk("tile_off_in_ready", bus.base_data_in_ready, 0);
        chk("tile_off_out_valid", bus.repsig_data_out_valid, 0);
      end
      if (prev_hold && tile_en) begin
        chk("stall_valid_held", bus.repsig_data_out_valid, 1);
        chk("stall_data_held", bus.repsig_data_out, prev_data);
      end
      if (prev_ce_low && tile_en == prev_te) begin
        chk("clk_en_valid_held", bus.repsig_data_out_valid, prev_valid);
        chk("clk_en_data_held", bus.repsig_data_out, prev_data);
        chk("clk_en_ready_held", bus.base_data_in_ready, prev_rdy);
      end
      if (bus.base_data_in_valid && bus.base_data_in_ready && clk_en) begin
        exp_q.push_back(model_tok(bus.base_data_in, stop_lvl));
        in_fire = 1;
        if (tp_arm && first_in < 0) first_in = cyc;
      end
      if (bus.repsig_data_out_valid && bus.repsig_data_out_ready && clk_en) begin
        got_q.push_back(bus.repsig_data_out);
        out_cnt++;
        last_out = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0h, expected no token", bus.repsig_data_out);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if (bus.repsig_data_out !== e) begin
            errors++;
            $display("FAIL stream_token: got %0h, expected %0h (t=%0t)", bus.repsig_data_out, e, $time);
          end
        end
      end
      if (bus.base_data_in_valid && !bus.base_data_in_ready && tile_en) saw_full = 1;
      prev_hold   = bus.repsig_data_out_valid && !(bus.repsig_data_out_ready && clk_en) && tile_en;
      prev_ce_low = !clk_en;
      prev_valid  = bus.repsig_data_out_valid;
      prev_rdy    = bus.base_data_in_ready;
      prev_te     = tile_en;
      prev_data   = bus.repsig_data_out;
    end
  end

  // ---------------- output consumer ----------------
  initial begin
    bus.repsig_data_out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.repsig_data_out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int gap_pct);
    int guard = 0;
    while ((src_q.size() > 0 || bus.base_data_in_valid) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (bus.base_data_in_valid && in_fire) bus.base_data_in_valid = 1'b0;
      if (!bus.base_data_in_valid && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        bus.base_data_in       = src_q.pop_front();
        bus.base_data_in_valid = 1'b1;
      end
    end
    chk("drive_done", src_q.size() + int'(bus.base_data_in_valid), 0);
    bus.base_data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_three_stalled();
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) src_q.push_back(rand_tok());
    drive(0);
    repeat (2) @(posedge clk);
    #1;
    chk("inflight_valid", bus.repsig_data_out_valid, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [16:0] tok;
    logic [15:0] lvl;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int base_cnt;
    vecs[0] = '{17'h00000, 16'd0, 17'h00001};
    vecs[1] = '{17'h00002, 16'd0, 17'h00001};
    vecs[2] = '{17'h00005, 16'd0, 17'h00001};
    vecs[3] = '{17'h10000, 16'd0, 17'h10000};
    vecs[4] = '{17'h10100, 16'd0, 17'h10100};
    vecs[5] = '{17'h00007, 16'd1, 17'h00001};
    vecs[6] = '{17'h10001, 16'd1, 17'h10002};
    vecs[7] = '{17'h10100, 16'd1, 17'h10100};

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; stop_lvl = 16'd0;
    bus.base_data_in = '0; bus.base_data_in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.base_data_in_ready, 0);
    chk("rst_out_valid", bus.repsig_data_out_valid, 0);
    chk("rst_out_data", bus.repsig_data_out, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.base_data_in_ready, 1);
    chk("post_rst_out_valid", bus.repsig_data_out_valid, 0);

    // Table vectors: basic stream, then stop offset
    rdy_pct = 100;
    for (int g = 0; g < 2; g++) begin
      int lo, hi;
      lo = (g == 0) ? 0 : 5;
      hi = (g == 0) ? 5 : 8;
      stop_lvl = vecs[lo].lvl;
      got_q.delete();
      for (int i = lo; i < hi; i++) src_q.push_back(vecs[i].tok);
      drive(0);
      drain();
      chk("tbl_count", got_q.size(), hi - lo);
      for (int i = lo; i < hi; i++)
        if (got_q.size() > 0) chk($sformatf("tbl_vec%0d", i), got_q.pop_front(), vecs[i].exp);
    end

    // Random stream under ~50% backpressure
    stop_lvl = 16'($urandom);
    rdy_pct  = 50;
    saw_full = 0;
    base_cnt = out_cnt;
    for (int i = 0; i < 200; i++) src_q.push_back(rand_tok());
    drive(10);
    drain();
    chk("bp_out_count", out_cnt - base_cnt, 200);
    chk("bp_saw_in_ready_low", saw_full, 1);

    // tile_en and clk_en windows in the middle of a stream
    rdy_pct  = 70;
    base_cnt = out_cnt;
    for (int i = 0; i < 60; i++) src_q.push_back(rand_tok());
    fork
      drive(0);
      begin
        repeat (15) @(posedge clk);
        #1 tile_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 tile_en = 1'b1;
        repeat (8) @(posedge clk);
        #1 clk_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 clk_en = 1'b1;
      end
    join
    drain();
    chk("enable_out_count", out_cnt - base_cnt, 60);

    // Flush with tokens in flight
    load_three_stalled();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_out_valid", bus.repsig_data_out_valid, 0);
    chk("flush_out_data", bus.repsig_data_out, 0);
    rdy_pct  = 100;
    base_cnt = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_no_stale", out_cnt - base_cnt, 0);
    chk("flush_in_ready", bus.base_data_in_ready, 1);
    src_q.push_back(17'h10003);
    drive(0);
    drain();
    chk("flush_recover", out_cnt - base_cnt, 1);

    // Asynchronous reset with tokens in flight
    load_three_stalled();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", bus.base_data_in_ready, 0);
    chk("arst_out_valid", bus.repsig_data_out_valid, 0);
    chk("arst_out_data", bus.repsig_data_out, 0);
    exp_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    rdy_pct  = 100;
    base_cnt = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_stale", out_cnt - base_cnt, 0);
    src_q.push_back(17'h00042);
    drive(0);
    drain();
    chk("arst_recover", out_cnt - base_cnt, 1);

    // Throughput: 100 back-to-back tokens, output always ready
    rdy_pct  = 100;
    repeat (2) @(posedge clk);
    first_in = -1;
    tp_arm   = 1;
    base_cnt = out_cnt;
    for (int i = 0; i < 100; i++) src_q.push_back(rand_tok());
    drive(0);
    drain();
    tp_arm = 0;
    chk("tp_out_count", out_cnt - base_cnt, 100);
    chk("tp_cycles", last_out - first_in + 1, 102);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
